ysyx_23060332_wbu: RTL and testbench

Write-back unit for the NPC core; it is the producer side of the register file write port (waddr/wdata/reg_wen).
- Accepts results from the EXU (ALU results) and the LSU (raw load words) over valid/ready handshakes.
- Arbitrates between the two sources and formats load data (sign/zero extend).
- Drives one registered write per cycle.
- Keeps a per-register busy scoreboard that the IDU reads for RAW stalls, plus a retired-instruction counter.

---
 rtl/ysyx_23060332_wbu.sv | 134 +++++++++++++
 tb/tb_ysyx_23060332_wbu.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060332_wbu.sv
// Write-back unit: arbitrates EXU/LSU results, formats loads, drives one registered
// regfile write per cycle, tracks a busy scoreboard and instret. Optional: YSYX_23060332_WBU_BYPASS_EN.
module ysyx_23060332_wbu #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_rd,
    input  logic             alu_wen,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [4:0]       lsu_rd,
    input  logic [2:0]       lsu_funct3,
    input  logic [1:0]       lsu_addr_lo,
    input  logic [XLEN-1:0]  lsu_rdata,
    input  logic             iss_valid,
    input  logic [4:0]       iss_rd,
    output logic [31:0]      busy_vec,
    output logic [4:0]       waddr,
    output logic [XLEN-1:0]  wdata,
    output logic             reg_wen,
    output logic             ld_err,
`ifdef YSYX_23060332_WBU_BYPASS_EN
    output logic             fwd_valid,
    output logic [4:0]       fwd_addr,
    output logic [XLEN-1:0]  fwd_data,
`endif
    output logic [CNT_W-1:0] instret
);

    logic [4:0]       waddr_q, waddr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic             reg_wen_q, reg_wen_d;
    logic             ld_err_q, ld_err_d;
    logic [31:0]      busy_q, busy_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic             hs_lsu, hs_alu, hs;
    logic [4:0]       win_rd;
    logic             win_wen;
    logic [XLEN-1:0]  win_data;
    logic             win_err;
    logic             do_write;
    logic [XLEN-1:0]  ld_val;
    logic             ld_bad;
    logic [7:0]       b8;
    logic [15:0]      h16;
    logic [31:0]      set_mask, clr_mask;

    assign lsu_ready = 1'b1;
    assign alu_ready = !lsu_valid;
    assign hs_lsu    = lsu_valid;
    assign hs_alu    = alu_valid && !lsu_valid;
    assign hs        = hs_lsu || hs_alu;

    // Load formatting on the aligned word
    always_comb begin
        b8     = lsu_rdata[{lsu_addr_lo, 3'b000} +: 8];
        h16    = lsu_addr_lo[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];
        ld_val = '0;
        ld_bad = 1'b0;
        case (lsu_funct3)
            3'b000:  ld_val = XLEN'($signed(b8));
            3'b100:  ld_val = XLEN'(b8);
            3'b001:  if (lsu_addr_lo[0]) ld_bad = 1'b1; else ld_val = XLEN'($signed(h16));
            3'b101:  if (lsu_addr_lo[0]) ld_bad = 1'b1; else ld_val = XLEN'(h16);
            3'b010:  if (lsu_addr_lo != 2'b00) ld_bad = 1'b1; else ld_val = XLEN'($signed(lsu_rdata[31:0]));
            default: ld_bad = 1'b1;
        endcase
    end

    always_comb begin
        win_rd   = hs_lsu ? lsu_rd : alu_rd;
        win_wen  = hs_lsu ? 1'b1 : alu_wen;
        win_err  = hs_lsu && ld_bad;
        win_data = hs_lsu ? (ld_bad ? '0 : ld_val) : alu_data;
        do_write = hs && win_wen && (win_rd != 5'd0) && !win_err;
    end

    always_comb begin
        reg_wen_d = do_write;
        ld_err_d  = win_err;
        waddr_d   = hs ? win_rd : waddr_q;
        wdata_d   = hs ? win_data : wdata_q;
        instret_d = instret_q + CNT_W'(hs);

        set_mask = '0;
        clr_mask = '0;
        if (hs && win_wen && (win_rd != 5'd0)) clr_mask[win_rd] = 1'b1;
        if (iss_valid && (iss_rd != 5'd0))     set_mask[iss_rd] = 1'b1;
        // clear first so a same-cycle reissue keeps the register busy
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q   <= '0;
            wdata_q   <= '0;
            reg_wen_q <= 1'b0;
            ld_err_q  <= 1'b0;
            busy_q    <= '0;
            instret_q <= '0;
        end else begin
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            reg_wen_q <= reg_wen_d;
            ld_err_q  <= ld_err_d;
            busy_q    <= busy_d;
            instret_q <= instret_d;
        end
    end

    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign reg_wen = reg_wen_q;
    assign ld_err  = ld_err_q;
    assign instret = instret_q;

`ifdef YSYX_23060332_WBU_BYPASS_EN
    assign fwd_valid = do_write;
    assign fwd_addr  = win_rd;
    assign fwd_data  = win_data;
    // the forwarded register is already resolvable by the IDU this cycle
    assign busy_vec  = busy_q & ~(do_write ? (32'd1 << win_rd) : 32'd0);
`else
    assign busy_vec  = busy_q;
`endif

endmodule

// File: tb/tb_ysyx_23060332_wbu.sv
// Self-checking bench for ysyx_23060332_wbu: directed scenarios plus randomized traffic
// checked against a behavioural model of the write-back rules.
module tb_ysyx_23060332_wbu;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             alu_valid, alu_ready, alu_wen;
    logic [4:0]       alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             lsu_valid, lsu_ready;
    logic [4:0]       lsu_rd;
    logic [2:0]       lsu_funct3;
    logic [1:0]       lsu_addr_lo;
    logic [XLEN-1:0]  lsu_rdata;
    logic             iss_valid;
    logic [4:0]       iss_rd;
    logic [31:0]      busy_vec;
    logic [4:0]       waddr;
    logic [XLEN-1:0]  wdata;
    logic             reg_wen, ld_err;
    logic [CNT_W-1:0] instret;
`ifdef YSYX_23060332_WBU_BYPASS_EN
    logic             fwd_valid;
    logic [4:0]       fwd_addr;
    logic [XLEN-1:0]  fwd_data;
`endif

    ysyx_23060332_wbu #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
        .alu_wen(alu_wen), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
        .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo), .lsu_rdata(lsu_rdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_vec),
        .waddr(waddr), .wdata(wdata), .reg_wen(reg_wen), .ld_err(ld_err),
`ifdef YSYX_23060332_WBU_BYPASS_EN
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
`endif
        .instret(instret)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Reference model state
    logic [4:0]       m_waddr;
    logic [31:0]      m_wdata;
    logic             m_wen, m_err;
    logic [63:0]      m_instret;
    logic [31:0]      m_busy;

    function automatic void model_reset();
        m_waddr = '0; m_wdata = '0; m_wen = 1'b0; m_err = 1'b0;
        m_instret = '0; m_busy = '0;
    endfunction

    // Load result from byte-lane arithmetic on the raw word
    function automatic void ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                     input logic [31:0] word, output bit err,
                                     output logic [31:0] val);
        longint unsigned w, x;
        w = 64'(word);
        err = 0;
        val = '0;
        case (f3)
            3'd0, 3'd4: begin
                x = (w >> (8 * lo)) & 64'hFF;
                if (f3 == 3'd0 && x >= 128) x = x + 64'hFFFF_FF00;
                val = x[31:0];
            end
            3'd1, 3'd5: begin
                if (lo % 2 == 1) err = 1;
                else begin
                    x = (w >> (8 * lo)) & 64'hFFFF;
                    if (f3 == 3'd1 && x >= 32768) x = x + 64'hFFFF_0000;
                    val = x[31:0];
                end
            end
            3'd2: if (lo != 0) err = 1; else val = word;
            default: err = 1;
        endcase
    endfunction

    function automatic void model_step();
        bit e;
        logic [31:0] v, clr, set;
        clr = '0; set = '0;
        m_wen = 1'b0; m_err = 1'b0;
        if (lsu_valid) begin
            ref_load(lsu_funct3, lsu_addr_lo, lsu_rdata, e, v);
            m_err   = e;
            m_waddr = lsu_rd;
            m_wdata = e ? 32'd0 : v;
            m_wen   = !e && lsu_rd != 0;
            if (lsu_rd != 0) clr[lsu_rd] = 1'b1;
            m_instret = m_instret + 1;
        end else if (alu_valid) begin
            m_waddr = alu_rd;
            m_wdata = alu_data;
            m_wen   = alu_wen && alu_rd != 0;
            if (alu_wen && alu_rd != 0) clr[alu_rd] = 1'b1;
            m_instret = m_instret + 1;
        end
        if (iss_valid && iss_rd != 0) set[iss_rd] = 1'b1;
        m_busy = (m_busy & ~clr) | set;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_wen = 0; alu_data = '0;
        lsu_valid = 0; lsu_rd = 0; lsu_funct3 = 0; lsu_addr_lo = 0; lsu_rdata = '0;
        iss_valid = 0; iss_rd = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        n_total++;
        if ({reg_wen, waddr, wdata, ld_err, busy_vec, instret} !== '0)
            $display("FAIL reset_outputs: got wen=%b waddr=%0d wdata=%h err=%b busy=%h instret=%0d expected all zero",
                     reg_wen, waddr, wdata, ld_err, busy_vec, instret);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        alu_valid = 1; alu_rd = 5; alu_wen = 1; alu_data = 32'hDEADBEEF;
        tick();
        n_total++;
        if (reg_wen !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF || instret !== 64'd1)
            $display("FAIL first_alu_write: got wen=%b waddr=%0d wdata=%h instret=%0d expected 1/5/deadbeef/1",
                     reg_wen, waddr, wdata, instret);
        else n_pass++;
        idle_inputs();
        tick();
        n_total++;
        if (reg_wen !== 1'b0 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF)
            $display("FAIL idle_hold: got wen=%b waddr=%0d wdata=%h expected 0/5/deadbeef", reg_wen, waddr, wdata);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [63:0] base;
        base = m_instret;
        lsu_valid = 1; lsu_rd = 3; lsu_funct3 = 3'b010; lsu_addr_lo = 0; lsu_rdata = $urandom;
        alu_valid = 1; alu_rd = 4; alu_wen = 1; alu_data = $urandom;
        #1;
        n_total++;
        if (alu_ready !== 1'b0 || lsu_ready !== 1'b1)
            $display("FAIL contention_ready: got alu_ready=%b lsu_ready=%b expected 0/1", alu_ready, lsu_ready);
        else n_pass++;
        tick();
        n_total++;
        if (reg_wen !== 1'b1 || waddr !== 5'd3 || wdata !== m_wdata)
            $display("FAIL contention_lsu_first: got wen=%b waddr=%0d wdata=%h expected 1/3/%h", reg_wen, waddr, wdata, m_wdata);
        else n_pass++;
        lsu_valid = 0;
        #1;
        n_total++;
        if (alu_ready !== 1'b1) $display("FAIL contention_alu_ready: got %b expected 1", alu_ready);
        else n_pass++;
        tick();
        alu_valid = 0;
        n_total++;
        if (reg_wen !== 1'b1 || waddr !== 5'd4 || wdata !== alu_data || instret !== base + 2)
            $display("FAIL contention_alu_second: got wen=%b waddr=%0d wdata=%h instret=%0d expected 1/4/%h/%0d",
                     reg_wen, waddr, wdata, instret, alu_data, base + 2);
        else n_pass++;
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [1:0]  los [4]  = '{2'd3, 2'd1, 2'd2, 2'd0};
        logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01};
        for (int i = 0; i < 4; i++) begin
            lsu_valid = 1; lsu_rd = 5'(10 + i); lsu_funct3 = f3s[i]; lsu_addr_lo = los[i];
            lsu_rdata = 32'h80FF7F01;
            tick();
            n_total++;
            if (reg_wen !== 1'b1 || wdata !== exps[i] || ld_err !== 1'b0)
                $display("FAIL load_ext_%0d: got wen=%b wdata=%h err=%b expected 1/%h/0", i, reg_wen, wdata, ld_err, exps[i]);
            else n_pass++;
        end
        for (int i = 0; i < 40; i++) begin
            lsu_funct3 = 3'($urandom_range(0, 7)); lsu_addr_lo = 2'($urandom);
            lsu_rd = 5'($urandom_range(1, 31)); lsu_rdata = $urandom;
            tick();
            n_total++;
            if (reg_wen !== m_wen || ld_err !== m_err || wdata !== m_wdata)
                $display("FAIL load_rand f3=%0d lo=%0d: got wen=%b err=%b wdata=%h expected %b/%b/%h",
                         lsu_funct3, lsu_addr_lo, reg_wen, ld_err, wdata, m_wen, m_err, m_wdata);
            else n_pass++;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_misaligned();
        logic [63:0] base;
        base = m_instret;
        lsu_valid = 1; lsu_rd = 9; lsu_funct3 = 3'b010; lsu_addr_lo = 2; lsu_rdata = $urandom;
        tick();
        idle_inputs();
        n_total++;
        if (ld_err !== 1'b1 || reg_wen !== 1'b0 || wdata !== 32'd0 || instret !== base + 1)
            $display("FAIL misaligned_lw: got err=%b wen=%b wdata=%h instret=%0d expected 1/0/0/%0d",
                     ld_err, reg_wen, wdata, instret, base + 1);
        else n_pass++;
        tick();
        n_total++;
        if (ld_err !== 1'b0) $display("FAIL misaligned_pulse: got err=%b expected 0", ld_err);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        iss_valid = 1; iss_rd = 7;
        tick();
        iss_valid = 0;
        n_total++;
        if (busy_vec[7] !== 1'b1) $display("FAIL sb_set: got busy[7]=%b expected 1", busy_vec[7]);
        else n_pass++;
        alu_valid = 1; alu_rd = 7; alu_wen = 1; alu_data = $urandom;
        iss_valid = 1; iss_rd = 7;
        tick();
        iss_valid = 0;
        n_total++;
        if (busy_vec[7] !== 1'b1) $display("FAIL sb_set_wins: got busy[7]=%b expected 1", busy_vec[7]);
        else n_pass++;
        tick();
        alu_valid = 0;
        n_total++;
        if (busy_vec[7] !== 1'b0) $display("FAIL sb_clear: got busy[7]=%b expected 0", busy_vec[7]);
        else n_pass++;
        iss_valid = 1; iss_rd = 0;
        tick();
        iss_valid = 0;
        n_total++;
        if (busy_vec[0] !== 1'b0 || busy_vec !== m_busy)
            $display("FAIL sb_x0: got busy=%h expected %h", busy_vec, m_busy);
        else n_pass++;
    endtask

    task automatic test_x0();
        logic [63:0] base;
        base = m_instret;
        alu_valid = 1; alu_rd = 0; alu_wen = 1; alu_data = 32'h1234;
`ifdef YSYX_23060332_WBU_BYPASS_EN
        #1;
        n_total++;
        if (fwd_valid !== 1'b0) $display("FAIL x0_fwd: got fwd_valid=%b expected 0", fwd_valid);
        else n_pass++;
`endif
        tick();
        alu_valid = 0;
        n_total++;
        if (reg_wen !== 1'b0 || instret !== base + 1)
            $display("FAIL x0_write: got wen=%b instret=%0d expected 0/%0d", reg_wen, instret, base + 1);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            alu_valid = 1'($urandom); alu_rd = 5'($urandom_range(0, 7)); alu_wen = 1'($urandom);
            alu_data = $urandom;
            lsu_valid = ($urandom_range(0, 3) == 0); lsu_rd = 5'($urandom_range(0, 7));
            lsu_funct3 = 3'($urandom); lsu_addr_lo = 2'($urandom); lsu_rdata = $urandom;
            iss_valid = 1'($urandom); iss_rd = 5'($urandom_range(0, 7));
            #1;
            n_total++;
            if (alu_ready !== !lsu_valid) $display("FAIL rand_ready: got %b expected %b", alu_ready, !lsu_valid);
            else n_pass++;
            tick();
            n_total++;
            if (reg_wen !== m_wen || ld_err !== m_err || instret !== m_instret || busy_vec !== m_busy
                || (m_wen && waddr !== m_waddr) || ((m_wen || m_err) && wdata !== m_wdata))
                $display("FAIL rand_cycle_%0d: got wen=%b err=%b waddr=%0d wdata=%h instret=%0d busy=%h expected %b/%b/%0d/%h/%0d/%h",
                         i, reg_wen, ld_err, waddr, wdata, instret, busy_vec, m_wen, m_err, m_waddr, m_wdata, m_instret, m_busy);
            else n_pass++;
            if (i == 150) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                n_total++;
                if ({reg_wen, ld_err, busy_vec, instret, waddr, wdata} !== '0)
                    $display("FAIL rand_async_reset: got wen=%b err=%b busy=%h instret=%0d expected zeros",
                             reg_wen, ld_err, busy_vec, instret);
                else n_pass++;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_load_ext();
        test_misaligned();
        test_scoreboard();
        test_x0();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
